// File: rtl/filter_bank_tdm.sv
// -----------------------------------------------------------------------------
// filter_bank_tdm
//   NBANDS biquad (second-order IIR) sections sharing one time-multiplexed
//   multiply-accumulate engine. An internal divider produces one sample tick
//   every DIV clocks. Each band takes 5 MAC cycles plus 1 write-back cycle.
//   All band outputs are presented together with a one-cycle Listo pulse.
//
//   Difference equation per band:
//     y[n] = b0*u0 + b1*u1 + b2*u2 - a1*y1 - a2*y2
//   Coefficients are Q(W-FRAC).FRAC. Products are 2W bits wide and are summed
//   in a 2W+3 bit accumulator. The result is acc >>> FRAC, reduced to W bits.
//
//   Build option:
//     FILTER_BANK_SAT_EN  defined   -> results are clamped to the W-bit range
//                         undefined -> results keep their low W bits (wrap)
//
// Ports:
//   CLK        in   system clock, rising edge
//   Reset      in   asynchronous active-low reset
//   u          in   signed input sample, captured on the sample tick
//   coef_we    in   coefficient write strobe (accepted only while idle)
//   coef_addr  in   band*5 + tap, tap order b0,b1,b2,a1,a2
//   coef_data  in   signed coefficient value
//   y          out  packed band outputs, band b at y[(b+1)*W-1 : b*W]
//   Listo      out  one-cycle pulse when y holds a new sample
//   overrun    out  sticky: a tick arrived while the engine was busy
//   coef_err   out  one-cycle pulse: a coefficient write was rejected
// -----------------------------------------------------------------------------
module filter_bank_tdm #(
   parameter int W      = 25,
   parameter int FRAC   = 20,
   parameter int NBANDS = 3,
   parameter int DIV    = 50
) (
   input  logic                            CLK,
   input  logic                            Reset,
   input  logic signed [W-1:0]             u,
   input  logic                            coef_we,
   input  logic [$clog2(5*NBANDS)-1:0]     coef_addr,
   input  logic signed [W-1:0]             coef_data,
   output logic [NBANDS*W-1:0]             y,
   output logic                            Listo,
   output logic                            overrun,
   output logic                            coef_err
);

   localparam int NCOEF = 5 * NBANDS;
   localparam int AW    = $clog2(NCOEF);
   localparam int BW    = (NBANDS > 1) ? $clog2(NBANDS) : 1;
   localparam int CW    = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int ACCW  = 2 * W + 3;

   typedef enum logic [1:0] {
      S_IDLE,
      S_MAC,
      S_WRITE,
      S_DONE
   } state_t;

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   state_t                 state_q;
   logic [CW-1:0]          cnt_q;
   logic [BW-1:0]          band_q;
   logic [2:0]             tap_q;
   logic signed [ACCW-1:0] acc_q;
   logic signed [W-1:0]    u0_q, u1_q, u2_q;
   logic signed [W-1:0]    coef_q  [NCOEF];
   logic signed [W-1:0]    y1_q    [NBANDS];
   logic signed [W-1:0]    y2_q    [NBANDS];
   logic signed [W-1:0]    stage_q [NBANDS];
   logic [NBANDS*W-1:0]    y_q;
   logic                   listo_q;
   logic                   overrun_q;
   logic                   coef_err_q;

   // ---------------------------------------------------------------------------
   // Datapath (combinational)
   // ---------------------------------------------------------------------------
   logic                   tick;
   logic                   coef_ok;
   logic [AW-1:0]          coef_idx;
   logic signed [W-1:0]    coef_sel;
   logic signed [W-1:0]    data_sel;
   logic signed [2*W-1:0]  prod;
   logic signed [ACCW-1:0] prod_ext;
   logic signed [ACCW-1:0] acc_d;
   logic signed [W-1:0]    result_d;

   assign tick     = (cnt_q == CW'(DIV - 1));
   assign coef_ok  = (state_q == S_IDLE) && ({1'b0, coef_addr} < (AW+1)'(NCOEF));
   assign coef_idx = AW'(int'(band_q) * 5 + int'(tap_q));
   assign coef_sel = coef_q[coef_idx];

   // NOTE: every always_comb output gets a default before the case, so no
   //       path leaves it unassigned and no latch is inferred.
   always_comb begin
      data_sel = '0;
      case (tap_q)
         3'd0:    data_sel = u0_q;
         3'd1:    data_sel = u1_q;
         3'd2:    data_sel = u2_q;
         3'd3:    data_sel = y1_q[band_q];
         3'd4:    data_sel = y2_q[band_q];
         default: data_sel = '0;
      endcase
   end

   assign prod     = (2*W)'(coef_sel) * (2*W)'(data_sel);
   assign prod_ext = ACCW'(prod);

   // Tap 0 loads the product instead of adding, which clears the accumulator
   // at the start of every band. Taps 3 and 4 are the feedback terms and are
   // subtracted.
   always_comb begin
      acc_d = acc_q;
      if (tap_q == 3'd0) begin
         acc_d = prod_ext;
      end else if (tap_q <= 3'd2) begin
         acc_d = acc_q + prod_ext;
      end else begin
         acc_d = acc_q - prod_ext;
      end
   end

`ifdef FILTER_BANK_SAT_EN
   logic signed [ACCW-1:0] shifted;

   assign shifted = acc_q >>> FRAC;

   // In range exactly when every bit above the W-bit sign position matches it.
   always_comb begin
      if ((shifted[ACCW-1:W-1] == '0) || (shifted[ACCW-1:W-1] == '1)) begin
         result_d = shifted[W-1:0];
      end else if (shifted[ACCW-1]) begin
         result_d = {1'b1, {(W-1){1'b0}}};
      end else begin
         result_d = {1'b0, {(W-1){1'b1}}};
      end
   end
`else
   // Two's-complement wrap: keep the low W bits of the shifted accumulator.
   assign result_d = W'(acc_q >>> FRAC);
`endif

   // ---------------------------------------------------------------------------
   // Sequencer and storage
   // ---------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments only, so every
   //       register samples pre-edge values regardless of statement order.
   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         band_q     <= '0;
         tap_q      <= '0;
         acc_q      <= '0;
         u0_q       <= '0;
         u1_q       <= '0;
         u2_q       <= '0;
         y_q        <= '0;
         listo_q    <= 1'b0;
         overrun_q  <= 1'b0;
         coef_err_q <= 1'b0;
         // NOTE: the coefficient and history arrays are small register files
         //       that must read back as zero after reset, so they are reset
         //       explicitly rather than inferred as RAM.
         for (int i = 0; i < NCOEF; i++) begin
            coef_q[i] <= '0;
         end
         for (int b = 0; b < NBANDS; b++) begin
            y1_q[b]    <= '0;
            y2_q[b]    <= '0;
            stage_q[b] <= '0;
         end
      end else begin
         cnt_q      <= tick ? '0 : cnt_q + CW'(1);
         listo_q    <= 1'b0;
         coef_err_q <= coef_we && !coef_ok;

         // Writes are accepted only while idle, including the tick cycle, so a
         // write in that cycle is already visible to the first MAC cycle.
         if (coef_we && coef_ok) begin
            coef_q[coef_addr] <= coef_data;
         end

         if (tick && (state_q != S_IDLE)) begin
            overrun_q <= 1'b1;
         end

         case (state_q)
            S_IDLE: begin
               if (tick) begin
                  u0_q    <= u;
                  band_q  <= '0;
                  tap_q   <= '0;
                  state_q <= S_MAC;
               end
            end

            S_MAC: begin
               acc_q <= acc_d;
               if (tap_q == 3'd4) begin
                  state_q <= S_WRITE;
               end else begin
                  tap_q <= tap_q + 3'd1;
               end
            end

            S_WRITE: begin
               stage_q[band_q] <= result_d;
               y1_q[band_q]    <= result_d;
               y2_q[band_q]    <= y1_q[band_q];
               tap_q           <= '0;
               if (band_q == BW'(NBANDS - 1)) begin
                  // The output register and Listo are loaded on the edge into
                  // DONE so the pulse is visible during the DONE cycle. The
                  // last band is taken straight from the result because its
                  // staging slot is only being written on this same edge.
                  for (int b = 0; b < NBANDS - 1; b++) begin
                     y_q[b*W +: W] <= stage_q[b];
                  end
                  y_q[(NBANDS-1)*W +: W] <= result_d;
                  listo_q <= 1'b1;
                  state_q <= S_DONE;
               end else begin
                  band_q  <= band_q + BW'(1);
                  state_q <= S_MAC;
               end
            end

            S_DONE: begin
               u2_q    <= u1_q;
               u1_q    <= u0_q;
               state_q <= S_IDLE;
            end

            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign y        = y_q;
   assign Listo    = listo_q;
   assign overrun  = overrun_q;
   assign coef_err = coef_err_q;

endmodule

// File: tb/tb_filter_bank_tdm.sv
// -----------------------------------------------------------------------------
// tb_filter_bank_tdm
//   Scoreboard bench for filter_bank_tdm. The driver issues coefficient writes
//   and samples, and at every sample tick pushes the expected band outputs plus
//   the cycle in which Listo must appear. A separate monitor pops and compares
//   on every Listo. Expected values come from literal constants for directed
//   cases and from a sample-level arithmetic model for random traffic.
//   A second instance with DIV=10 exercises the overrun flag.
// -----------------------------------------------------------------------------
module tb_filter_bank_tdm;

   localparam int W     = 25;
   localparam int FRAC  = 20;
   localparam int NB    = 3;
   localparam int DIV   = 50;
   localparam int DIV_F = 10;
   localparam int NC    = 5 * NB;
   localparam int AW    = $clog2(NC);
   localparam int LAT   = 6 * NB + 1;
   localparam longint MAXV = (longint'(1) <<< (W - 1)) - 1;
   localparam longint MINV = -(longint'(1) <<< (W - 1));
`ifdef FILTER_BANK_SAT_EN
   localparam longint SAT_EXP = 16777215;
`else
   localparam longint SAT_EXP = -32;
`endif

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b1;
   logic signed [W-1:0]  u = '0;
   logic                 coef_we = 1'b0;
   logic [AW-1:0]        coef_addr = '0;
   logic signed [W-1:0]  coef_data = '0;
   logic [NB*W-1:0]      y;
   logic                 listo, overrun, coef_err;

   logic                 coef_we_f = 1'b0;
   logic [AW-1:0]        coef_addr_f = '0;
   logic signed [W-1:0]  coef_data_f = '0;
   logic [NB*W-1:0]      y_f;
   logic                 listo_f, overrun_f, coef_err_f;

   always #5 clk = ~clk;

   filter_bank_tdm #(.W(W), .FRAC(FRAC), .NBANDS(NB), .DIV(DIV)) u_dut (
      .CLK(clk), .Reset(rst_n), .u(u),
      .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
      .y(y), .Listo(listo), .overrun(overrun), .coef_err(coef_err)
   );

   filter_bank_tdm #(.W(W), .FRAC(FRAC), .NBANDS(NB), .DIV(DIV_F)) u_dut_fast (
      .CLK(clk), .Reset(rst_n), .u(u),
      .coef_we(coef_we_f), .coef_addr(coef_addr_f), .coef_data(coef_data_f),
      .y(y_f), .Listo(listo_f), .overrun(overrun_f), .coef_err(coef_err_f)
   );

   // Bench-side cycle count since reset release: after edge k it reads k.
   int cyc;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Reference model: one call per sample, plain integer arithmetic
   // ---------------------------------------------------------------------------
   longint m_coef [NC];
   longint m_u1, m_u2;
   longint m_y1 [NB];
   longint m_y2 [NB];

   function automatic longint fit(input longint v);
`ifdef FILTER_BANK_SAT_EN
      if (v > MAXV) return MAXV;
      if (v < MINV) return MINV;
      return v;
`else
      logic signed [W-1:0] t;
      t = v[W-1:0];
      return longint'(t);
`endif
   endfunction

   function automatic logic [NB*W-1:0] model_step(input longint uv);
      logic [NB*W-1:0] out;
      longint acc, r;
      out = '0;
      for (int b = 0; b < NB; b++) begin
         acc = m_coef[5*b] * uv + m_coef[5*b+1] * m_u1 + m_coef[5*b+2] * m_u2
             - m_coef[5*b+3] * m_y1[b] - m_coef[5*b+4] * m_y2[b];
         r = fit(acc >>> FRAC);
         m_y2[b] = m_y1[b];
         m_y1[b] = r;
         out[b*W +: W] = r[W-1:0];
      end
      m_u2 = m_u1;
      m_u1 = uv;
      return out;
   endfunction

   function automatic void model_clear();
      for (int i = 0; i < NC; i++) m_coef[i] = 0;
      for (int b = 0; b < NB; b++) begin
         m_y1[b] = 0;
         m_y2[b] = 0;
      end
      m_u1 = 0;
      m_u2 = 0;
   endfunction

   function automatic logic [NB*W-1:0] pack3(input longint b0, input longint b1, input longint b2);
      return {W'(b2), W'(b1), W'(b0)};
   endfunction

   // ---------------------------------------------------------------------------
   // Scoreboard and monitor
   // ---------------------------------------------------------------------------
   typedef struct {
      logic [NB*W-1:0] y;
      int              due;
   } exp_t;

   exp_t            sb [$];
   exp_t            mon_e;
   logic [NB*W-1:0] y_hold = '0;

   always @(negedge clk) begin
      if (rst_n) begin
         if (listo) begin
            if (sb.size() == 0) begin
               check("listo_unexpected", listo, 0);
            end else begin
               mon_e = sb.pop_front();
               check("y", y, mon_e.y);
               check("listo_latency", cyc, mon_e.due);
            end
            y_hold = y;
         end else begin
            check("y_stable", y, y_hold);
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Driver tasks (all called at a falling edge)
   // ---------------------------------------------------------------------------
   task automatic do_reset();
      rst_n   = 1'b0;
      coef_we = 1'b0;
      sb.delete();
      y_hold  = '0;
      model_clear();
      #1;
      check("rst_y", y, 0);
      check("rst_listo", listo, 0);
      check("rst_overrun", overrun, 0);
      check("rst_coef_err", coef_err, 0);
      check("rst_y_fast", y_f, 0);
      check("rst_overrun_fast", overrun_f, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic wr(input int a, input logic signed [W-1:0] d, input bit expect_ok);
      coef_we   = 1'b1;
      coef_addr = AW'(a);
      coef_data = d;
      @(negedge clk);
      coef_we = 1'b0;
      check("coef_err", coef_err, !expect_ok);
      if (expect_ok) m_coef[a] = d;
   endtask

   task automatic goto_tick();
      while (cyc % DIV != DIV - 1) @(negedge clk);
   endtask

   // One sample: optional write in the tick cycle, optional write during MAC.
   task automatic sample(input logic signed [W-1:0] uv, input bit use_model,
                         input logic [NB*W-1:0] lit,
                         input int tw_addr, input logic signed [W-1:0] tw_data,
                         input int mac_addr, input logic signed [W-1:0] mac_data);
      exp_t e;
      goto_tick();
      u = uv;
      if (tw_addr >= 0) begin
         coef_we   = 1'b1;
         coef_addr = AW'(tw_addr);
         coef_data = tw_data;
         m_coef[tw_addr] = tw_data;
      end
      e.y   = model_step(uv);
      if (!use_model) e.y = lit;
      e.due = cyc + LAT;
      sb.push_back(e);
      @(negedge clk);
      coef_we = 1'b0;
      if (tw_addr >= 0) check("coef_err_tick_write", coef_err, 0);
      if (mac_addr >= 0) wr(mac_addr, mac_data, 1'b0);
      repeat (20) @(negedge clk);
   endtask

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   int k, a, ta, ma;

   initial begin
      #3;
      do_reset();

      // Overrun on the fast instance: ticks at cycles 9, 19, 29, 39.
      while (cyc < 48) begin
         @(negedge clk);
         case (cyc)
            18: check("overrun_before_2nd_tick", overrun_f, 0);
            21: check("overrun_after_2nd_tick", overrun_f, 1);
            28: check("fast_listo_1st", listo_f, 1);
            38: check("fast_listo_from_ignored_tick", listo_f, 0);
            45: check("overrun_sticky", overrun_f, 1);
            48: check("fast_listo_2nd", listo_f, 1);
            default: ;
         endcase
      end
      do_reset();

      // Pass-through on band 0.
      wr(0, 25'sd1048576, 1'b1);
      sample(25'sd1000, 1'b0, pack3(1000, 0, 0), -1, '0, -1, '0);

      // Abort mid-computation, then zero output because coefficients cleared.
      goto_tick();
      u = 25'sd1000;
      repeat (3) @(negedge clk);
      do_reset();
      sample(25'sd1000, 1'b0, pack3(0, 0, 0), -1, '0, -1, '0);

      // First-order recursion on band 1.
      do_reset();
      wr(5, 25'sd524288, 1'b1);
      wr(8, -25'sd524288, 1'b1);
      sample(25'sd4096, 1'b0, pack3(0, 2048, 0), -1, '0, -1, '0);
      sample(25'sd4096, 1'b0, pack3(0, 3072, 0), -1, '0, -1, '0);
      sample(25'sd4096, 1'b0, pack3(0, 3584, 0), -1, '0, -1, '0);
      sample(25'sd4096, 1'b0, pack3(0, 3840, 0), -1, '0, -1, '0);

      // One-sample delay on band 2.
      do_reset();
      wr(11, 25'sd1048576, 1'b1);
      sample(25'sd5, 1'b0, pack3(0, 0, 0), -1, '0, -1, '0);
      sample(25'sd7, 1'b0, pack3(0, 0, 5), -1, '0, -1, '0);
      sample(25'sd9, 1'b0, pack3(0, 0, 7), -1, '0, -1, '0);

      // Full-scale product, out-of-range address, and a write during MAC that
      // must not change b0 for the following sample.
      do_reset();
      wr(0, 25'sd16777215, 1'b1);
      wr(NC, 25'sd123, 1'b0);
      sample(25'sd16777215, 1'b0, pack3(SAT_EXP, 0, 0), -1, '0, 0, '0);
      sample(25'sd16777215, 1'b0, pack3(SAT_EXP, 0, 0), -1, '0, -1, '0);

      // Random traffic against the model.
      do_reset();
      for (int n = 0; n < 40; n++) begin
         k = $urandom_range(0, 3);
         for (int i = 0; i < k; i++) begin
            a = $urandom_range(0, NC);
            wr(a, W'($urandom), a < NC);
         end
         ta = ($urandom_range(0, 3) == 0) ? $urandom_range(0, NC - 1) : -1;
         ma = (n % 4 == 1) ? $urandom_range(0, NC - 1) : -1;
         sample(W'($urandom), 1'b1, '0, ta, W'($urandom), ma, W'($urandom));
      end

      for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
      check("scoreboard_drained", sb.size(), 0);
      check("overrun_main", overrun, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/filter_bank_tdm.md
Name: filter_bank_tdm

Overview:
Parametrised multi-band IIR filter bank, successor to the fixed three-band filter. It runs NBANDS second-order (biquad) sections through one time-multiplexed multiply-accumulate engine. An internal divider sets the sample rate, and coefficients are loaded at run time through a write port. All band outputs update together on one Listo pulse per sample.

Parameters:
W, 25, signed sample width (input and each band output)
FRAC, 20, fractional bits of coefficients (Q(W-FRAC).FRAC)
NBANDS, 3, number of biquad bands (1..8)
DIV, 50, CLK cycles per sample period; must be >= 6*NBANDS+2

Ports:
CLK  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-low reset
u  in  W  signed input sample, captured on the sample tick
coef_we  in  1  coefficient write strobe, one cycle
coef_addr  in  clog2(5*NBANDS)  address = band*5 + tap; tap order b0,b1,b2,a1,a2
coef_data  in  W  signed coefficient value
y  out  NBANDS*W  packed band outputs; band b occupies y[(b+1)*W-1 : b*W]
Listo  out  1  one-cycle pulse when y holds the new sample
overrun  out  1  sticky flag: a sample tick arrived while the engine was busy
coef_err  out  1  one-cycle pulse: a coefficient write was rejected

Behaviour:
- Reset low, applied asynchronously: y, Listo, overrun, coef_err = 0; divider = 0; all coefficients = 0; u1, u2, per-band y1, y2 = 0; FSM = IDLE.
- Divider counts 0..DIV-1 and wraps. Tick = (count == DIV-1).
- Difference equation per band: y[n] = b0*u0 + b1*u1 + b2*u2 - a1*y1 - a2*y2.
- Input history u0, u1, u2 is shared by all bands. Output history y1, y2 is stored per band.
- Products are W x W -> 2W bits. The accumulator is 2W+3 bits, signed, and is cleared at the start of each band.
- Result = accumulator >>> FRAC (arithmetic shift, truncation toward minus infinity), then reduced to W bits (see Optional Feature).
- FSM states:
  - IDLE: on tick, u0 <= u, go to MAC with band = 0, tap = 0.
  - MAC: one product accumulated per cycle, tap 0..4. After tap 4, go to WRITE.
  - WRITE: result goes into a staging register for this band; y2 <= y1 and y1 <= result for this band. Band increments; if band == NBANDS-1, go to DONE, else return to MAC with tap = 0.
  - DONE: y <= all staging values at once; Listo = 1; u2 <= u1 and u1 <= u0; return to IDLE.
- Latency: Listo is asserted 6*NBANDS+1 cycles after the tick cycle (19 cycles at default). y is stable between Listo pulses.
- Tick while FSM != IDLE: the tick is ignored, overrun is set to 1, and the current computation completes unaffected. overrun is cleared only by reset.
- Coefficient write in IDLE: the coefficient is written at the next edge and is used from the next tick onward. If a tick occurs in the same cycle, the write lands and the new value is used in that computation.
- Coefficient write while FSM != IDLE, or with coef_addr >= 5*NBANDS: the write is dropped and coef_err pulses for 1 cycle.
- Reset mid-computation: the abort is immediate; partial results are discarded and no Listo is produced.

Optional Feature:
FILTER_BANK_SAT_EN defined: each shifted result outside [-2^(W-1), 2^(W-1)-1] is clamped to the nearest bound before it is stored in y and y1. Not defined: the low W bits are kept (two's-complement wrap). Coefficient storage and the accumulator are identical in both builds.

Test Plan:
- Reset: drive Reset low mid-run -> y=0, Listo=0, overrun=0 in the same cycle; all coefficients read back as 0 (zero output after the next tick with nonzero u).
- Pass-through: band0 b0 = 1048576 (1.0), all other coefficients 0, u = 1000 -> Listo 19 cycles after the tick, band0 = 1000, bands 1 and 2 = 0.
- Recursion: band1 b0 = 524288, a1 = -524288, step u = 4096 -> successive band1 outputs 2048, 3072, 3584, 3840.
- Two-tap FIR: band2 b1 = 1048576, u sequence 5, 7, 9 -> band2 outputs 0, 5, 7 (one-sample delay).
- Saturation: band0 b0 = 2^24-1, u = 2^24-1 -> band0 = 16777215 with FILTER_BANK_SAT_EN; band0 = low 25 bits of the shifted product without it.
- Overrun and coef_err: instance DIV=10 with NBANDS=3 -> overrun = 1 after the second tick; a write issued during MAC -> coef_err pulses and the coefficient is unchanged.
